// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and default widths for the APB completer
package apb_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_t;

endpackage

// File: rtl/apb_regfile.sv
// rtl/apb_regfile.sv - word-indexed register file, one write port, one registered read port
module apb_regfile
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage array: cleared by reset so unwritten words read back as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read data register: only a read request reloads it, so it holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/apb_slave.sv
// rtl/apb_slave.sv - APB completer over a register file; optional wait states via APB_WAIT_STATES_EN
module apb_slave
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WAIT_STATES = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY
);

    apb_state_t state;
    apb_state_t next_state;
    logic       ready;
    logic       wait_done;
    logic       wr_en;
    logic       rd_en;

`ifdef APB_WAIT_STATES_EN
    localparam logic [3:0] WAIT_TARGET = 4'(WAIT_STATES);

    logic [3:0] wait_cnt;

    // Wait counter: zeroed while idle so every access phase starts counting from zero
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
        end else if (PSEL && PENABLE && !wait_done) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign wait_done = (wait_cnt == WAIT_TARGET);
`else
    logic unused_wait_cfg;

    assign unused_wait_cfg = (WAIT_STATES != 0);
    assign wait_done       = 1'b1;
`endif

    // State register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and ready decode; PENABLE seen in IDLE is ignored
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                ready = PSEL && PENABLE && wait_done;
                if (!PSEL) begin
                    next_state = IDLE;
                end else if (ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign PREADY = ready;

    // Writes commit only on the completing edge, using the address/data present then
    assign wr_en = ready && PWRITE;

    // Reads fetch at the setup edge so PRDATA is valid for the whole access phase
    assign rd_en = (state == IDLE) && PSEL && !PENABLE && !PWRITE;

    apb_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regfile (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .wr_en   (wr_en),
        .wr_addr (PADDR),
        .wr_data (PWDATA),
        .rd_en   (rd_en),
        .rd_addr (PADDR),
        .rd_data (PRDATA)
    );

endmodule

// File: tb/tb_apb_slave.sv
// tb/tb_apb_slave.sv - self-checking bench for apb_slave with a memory reference model
module tb_apb_slave;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int WS = 2;
`ifdef APB_WAIT_STATES_EN
    localparam int EXP_WAIT = WS;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic [AW-1:0] PADDR = '0;
    logic          PSEL = 1'b0;
    logic          PENABLE = 1'b0;
    logic          PWRITE = 1'b0;
    logic [DW-1:0] PWDATA = '0;
    logic [DW-1:0] PRDATA;
    logic          PREADY;

    logic [DW-1:0] model [1 << AW];
    logic [DW-1:0] last_rd;
    logic [DW-1:0] rdata;
    int            n_cmp = 0;
    int            n_err = 0;

    apb_slave #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .WAIT_STATES (WS)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < (1 << AW); i++) model[i] = '0;
        last_rd = '0;
    endtask

    // Setup phase; PREADY must be low and PRDATA must still hold the last read value
    task automatic setup(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        #1;
        check("setup_pready", {31'd0, PREADY}, 32'd0);
        check("prdata_hold", PRDATA, last_rd);
    endtask

    // Access phase; optionally re-drive address/data, then wait (bounded) for PREADY
    task automatic access(input bit chg, input logic [AW-1:0] a2, input logic [DW-1:0] d2);
        int waits;
        waits = 0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        if (chg) begin
            PADDR = a2; PWDATA = d2;
        end
        #1;
        while (PREADY !== 1'b1 && waits < 20) begin
            @(negedge PCLK);
            #1;
            waits++;
        end
        check("access_pready", {31'd0, PREADY}, 32'd1);
        check("wait_cycles", waits, EXP_WAIT);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        setup(1'b1, a, d);
        access(1'b0, '0, '0);
        model[a] = d;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        setup(1'b0, a, '0);
        access(1'b0, '0, '0);
        d = PRDATA;
        last_rd = model[a];
    endtask

    task automatic go_idle();
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        model_clear();

        // Reset state
        #12;
        check("rst_pready", {31'd0, PREADY}, 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        // Basic write/read
        do_write(8'h10, 32'hA5A5A5A5);
        do_write(8'h20, 32'h12345678);
        do_read(8'h10, rdata); check("rd_10", rdata, model[8'h10]);
        do_read(8'h20, rdata); check("rd_20", rdata, model[8'h20]);
        go_idle();

        // Unwritten words and top address
        do_read(8'h30, rdata); check("rd_30_zero", rdata, 32'd0);
        do_read(8'hFF, rdata); check("rd_ff_zero", rdata, 32'd0);
        do_write(8'hFF, 32'hDEADBEEF);
        do_read(8'hFF, rdata); check("rd_ff", rdata, 32'hDEADBEEF);
        do_read(8'h00, rdata); check("rd_00_zero", rdata, 32'd0);

        // Back-to-back write then read of the same word
        do_write(8'h05, 32'h1);
        do_read(8'h05, rdata); check("b2b_05", rdata, 32'h1);
        go_idle();
        #1;
        check("prdata_after_idle", PRDATA, 32'h1);

        // Aborted transfer: PSEL dropped after setup
        setup(1'b1, 8'h40, 32'h0000CAFE);
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        #1;
        check("abort_pready", {31'd0, PREADY}, 32'd0);
        do_read(8'h40, rdata); check("abort_40", rdata, 32'd0);
        go_idle();

        // PENABLE asserted in IDLE is ignored
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h41; PWDATA = 32'h99;
        #1;
        check("idle_en_pready0", {31'd0, PREADY}, 32'd0);
        @(negedge PCLK);
        #1;
        check("idle_en_pready1", {31'd0, PREADY}, 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        do_read(8'h41, rdata); check("idle_en_41", rdata, 32'd0);

        // Address/data changed during access: completion values win
        setup(1'b1, 8'h60, 32'h111);
        access(1'b1, 8'h61, 32'h222);
        model[8'h61] = 32'h222;
        do_read(8'h60, rdata); check("chg_60", rdata, 32'd0);
        do_read(8'h61, rdata); check("chg_61", rdata, 32'h222);

        // Wait-state sized transfer
        do_write(8'h22, 32'h77);
        do_read(8'h22, rdata); check("ws_22", rdata, 32'h77);

        // Randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                do_write(ra, $urandom);
            end else begin
                do_read(ra, rd);
                check("rand_rd", rd, model[ra]);
            end
            if ($urandom_range(0, 3) == 0) go_idle();
        end
        go_idle();

        // Reset during the access phase of a write
        do_read(8'h22, rdata);
        check("pre_rst_rd", rdata, 32'h77);
        setup(1'b1, 8'h10, 32'h55);
        @(negedge PCLK);
        PENABLE = 1'b1;
        #2;
        PRESETn = 1'b0;
        #1;
        check("midrst_pready", {31'd0, PREADY}, 32'd0);
        check("midrst_prdata", PRDATA, 32'd0);
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        model_clear();
        do_read(8'h10, rdata); check("post_rst_10", rdata, 32'd0);
        do_read(8'h22, rdata); check("post_rst_22", rdata, 32'd0);
        go_idle();

        @(negedge PCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
